// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between WB and a
// buffered multi-cycle result stream, with starvation-forced draining.
module rf_wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wb_vld,
  input  logic                          i_wb_rd_wen,
  input  logic [4:0]                    i_wb_rd_waddr,
  input  logic [31:0]                   i_wb_res,
  input  logic                          i_mc_vld,
  output logic                          o_mc_rdy,
  input  logic [4:0]                    i_mc_rd_waddr,
  input  logic [31:0]                   i_mc_res,
  output logic                          o_rd_wen,
  output logic [4:0]                    o_rd_waddr,
  output logic [31:0]                   o_rd_wdata,
  output logic                          o_src,
  output logic                          o_wb_stall,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SMAX_C = SW'(STARVE_MAX);

  logic [4:0]    mem_addr [FIFO_DEPTH];
  logic [31:0]   mem_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;

  logic full;
  logic empty;
  logic pipe_req;
  logic push;
  logic push_wr;
  logic head_win;
  logic pop;

  assign full     = (cnt_q == DEPTH_C);
  assign empty    = (cnt_q == '0);
  assign pipe_req = i_wb_vld & i_wb_rd_wen & (i_wb_rd_waddr != 5'd0);
  assign o_mc_rdy = ~full & ~i_rst;
  assign push     = i_mc_vld & o_mc_rdy;
  assign push_wr  = push & (i_mc_rd_waddr != 5'd0);
  // Head wins when the pipe is idle or has starved the head long enough.
  assign head_win = ~i_rst & ~empty & (~pipe_req | (starve_q == SMAX_C));
  assign pop      = head_win;
  assign o_fifo_cnt = cnt_q;

  // Write-port mux: FIFO head when granted, otherwise the WB stage.
  always_comb begin
    o_rd_wen   = 1'b0;
    o_rd_waddr = 5'd0;
    o_rd_wdata = 32'd0;
    o_src      = 1'b0;
    o_wb_stall = 1'b0;
    if (head_win) begin
      o_rd_wen   = 1'b1;
      o_rd_waddr = mem_addr[rd_ptr_q];
      o_rd_wdata = mem_data[rd_ptr_q];
      o_src      = 1'b1;
      o_wb_stall = pipe_req;
    end else if (!i_rst) begin
      o_rd_wen   = pipe_req;
      o_rd_waddr = i_wb_rd_waddr;
      o_rd_wdata = i_wb_res;
    end
  end

  // Starvation counter: counts denied cycles of a waiting head.
  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (starve_q != SMAX_C) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // FIFO storage; x0 results are acknowledged but never stored.
  always_ff @(posedge i_clk) begin
    if (push_wr) begin
      mem_addr[wr_ptr_q] <= i_mc_rd_waddr;
      mem_data[wr_ptr_q] <= i_mc_res;
    end
  end

  // Pointers, occupancy and starvation state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      if (push_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q    <= cnt_q + CW'(push_wr) - CW'(pop);
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed checks of the write-port arbiter
// with default FIFO_DEPTH=2 and STARVE_MAX=4.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_vld;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_res;
  logic        mc_vld;
  logic        mc_rdy;
  logic [4:0]  mc_addr;
  logic [31:0] mc_res;
  logic        rd_wen;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        src;
  logic        stall;
  logic [1:0]  fcnt;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wb_vld      (wb_vld),
    .i_wb_rd_wen   (wb_wen),
    .i_wb_rd_waddr (wb_addr),
    .i_wb_res      (wb_res),
    .i_mc_vld      (mc_vld),
    .o_mc_rdy      (mc_rdy),
    .i_mc_rd_waddr (mc_addr),
    .i_mc_res      (mc_res),
    .o_rd_wen      (rd_wen),
    .o_rd_waddr    (rd_waddr),
    .o_rd_wdata    (rd_wdata),
    .o_src         (src),
    .o_wb_stall    (stall),
    .o_fifo_cnt    (fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_vld  = v;
    wb_wen  = v;
    wb_addr = a;
    wb_res  = d;
  endtask

  task automatic mc(input logic v, input logic [4:0] a, input logic [31:0] d);
    mc_vld  = v;
    mc_addr = a;
    mc_res  = d;
  endtask

  // Port check helper: write enable, source, stall.
  task automatic port(input string tag, input logic w, input logic s,
                      input logic st);
    chk({tag, "_wen"}, 32'(rd_wen), 32'(w));
    chk({tag, "_src"}, 32'(src), 32'(s));
    chk({tag, "_stall"}, 32'(stall), 32'(st));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    mc(1'b0, 5'd0, 32'd0);
    // Reset state
    cyc();
    #1;
    port("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_rdy", 32'(mc_rdy), 32'd0);
    chk("rst_cnt", 32'(fcnt), 32'd0);

    // Pipe only
    cyc();
    rst = 1'b0;
    wb(1'b1, 5'd5, 32'h11);
    #1;
    port("pipe", 1'b1, 1'b0, 1'b0);
    chk("pipe_addr", 32'(rd_waddr), 32'd5);
    chk("pipe_data", rd_wdata, 32'h11);
    chk("pipe_cnt", 32'(fcnt), 32'd0);

    // Idle pipe, MC result x7
    cyc();
    wb(1'b0, 5'd0, 32'd0);
    mc(1'b1, 5'd7, 32'hAB);
    #1;
    chk("idle_rdy", 32'(mc_rdy), 32'd1);
    chk("idle_nowr", 32'(rd_wen), 32'd0);
    cyc();
    mc(1'b0, 5'd0, 32'd0);
    #1;
    chk("idle_cnt1", 32'(fcnt), 32'd1);
    port("idle_head", 1'b1, 1'b1, 1'b0);
    chk("idle_addr", 32'(rd_waddr), 32'd7);
    chk("idle_data", rd_wdata, 32'hAB);
    cyc();
    #1;
    chk("idle_cnt0", 32'(fcnt), 32'd0);
    chk("idle_wen0", 32'(rd_wen), 32'd0);

    // Starvation: continuous WB x3, one MC entry x9
    cyc();
    wb(1'b1, 5'd3, 32'h33);
    mc(1'b1, 5'd9, 32'h99);
    #1;
    port("stv_push", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      mc(1'b0, 5'd0, 32'd0);
      #1;
      port($sformatf("stv_wb%0d", i), 1'b1, 1'b0, 1'b0);
      chk($sformatf("stv_addr%0d", i), 32'(rd_waddr), 32'd3);
    end
    cyc();
    #1;
    port("stv_force", 1'b1, 1'b1, 1'b1);
    chk("stv_faddr", 32'(rd_waddr), 32'd9);
    chk("stv_fdata", rd_wdata, 32'h99);
    cyc();
    #1;
    port("stv_held", 1'b1, 1'b0, 1'b0);
    chk("stv_haddr", 32'(rd_waddr), 32'd3);
    chk("stv_cnt", 32'(fcnt), 32'd0);

    // Full: push x10, x11 while pipe busy
    cyc();
    mc(1'b1, 5'd10, 32'hA0);
    cyc();
    mc(1'b1, 5'd11, 32'hB1);
    #1;
    chk("full_cnt1", 32'(fcnt), 32'd1);
    chk("full_rdy1", 32'(mc_rdy), 32'd1);
    cyc();
    mc(1'b1, 5'd12, 32'hC2);
    #1;
    chk("full_cnt2", 32'(fcnt), 32'd2);
    chk("full_rdy0", 32'(mc_rdy), 32'd0);
    port("full_c0", 1'b1, 1'b0, 1'b0);
    cyc();
    #1;
    port("full_c1", 1'b1, 1'b0, 1'b0);
    cyc();
    #1;
    port("full_c2", 1'b1, 1'b0, 1'b0);
    chk("full_c2cnt", 32'(fcnt), 32'd2);
    cyc();
    #1;
    port("full_pop", 1'b1, 1'b1, 1'b1);
    chk("full_popaddr", 32'(rd_waddr), 32'd10);
    chk("full_nopt", 32'(mc_rdy), 32'd0);
    cyc();
    wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("full_rdyback", 32'(mc_rdy), 32'd1);
    chk("full_cntback", 32'(fcnt), 32'd1);
    port("full_h2", 1'b1, 1'b1, 1'b0);
    chk("full_h2addr", 32'(rd_waddr), 32'd11);
    chk("full_h2data", rd_wdata, 32'hB1);
    cyc();
    mc(1'b0, 5'd0, 32'd0);
    #1;
    chk("pp_cnt", 32'(fcnt), 32'd1);
    chk("pp_addr", 32'(rd_waddr), 32'd12);
    chk("pp_data", rd_wdata, 32'hC2);
    cyc();
    #1;
    chk("pp_cnt0", 32'(fcnt), 32'd0);
    chk("pp_wen0", 32'(rd_wen), 32'd0);

    // x0 writes
    cyc();
    wb(1'b1, 5'd0, 32'h55);
    #1;
    port("x0_wb", 1'b0, 1'b0, 1'b0);
    cyc();
    wb(1'b0, 5'd0, 32'd0);
    mc(1'b1, 5'd0, 32'h77);
    #1;
    chk("x0_rdy", 32'(mc_rdy), 32'd1);
    cyc();
    mc(1'b0, 5'd0, 32'd0);
    #1;
    chk("x0_cnt", 32'(fcnt), 32'd0);
    chk("x0_wen", 32'(rd_wen), 32'd0);

    // Reset with two entries buffered
    cyc();
    wb(1'b1, 5'd4, 32'h44);
    mc(1'b1, 5'd13, 32'hD3);
    cyc();
    mc(1'b1, 5'd14, 32'hE4);
    cyc();
    mc(1'b0, 5'd0, 32'd0);
    #1;
    chk("rr_cnt2", 32'(fcnt), 32'd2);
    rst = 1'b1;
    #1;
    port("rr_rst", 1'b0, 1'b0, 1'b0);
    chk("rr_rdy", 32'(mc_rdy), 32'd0);
    chk("rr_addr", 32'(rd_waddr), 32'd0);
    chk("rr_data", rd_wdata, 32'd0);
    cyc();
    rst = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("rr_cnt0", 32'(fcnt), 32'd0);
    chk("rr_rdy1", 32'(mc_rdy), 32'd1);
    chk("rr_wen0", 32'(rd_wen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
